input_skew_buffer: RTL and testbench

- Parametrised successor to the CNN input stage.
- Accepts an IMG x IMG image through a valid/ready stream and stores it unpadded. Zero padding is generated on read.
- Emits K vertically adjacent padded rows per column beat to the systolic array, with lane k skewed by k cycles.
- Streams windows as soon as the rows each window needs have arrived; it does not wait for the full frame.

---
 rtl/input_skew_buffer.sv | 164 ++++++++++++++++
 tb/tb_input_skew_buffer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_skew_buffer.sv
// Stores an IMG x IMG frame unpadded and streams K zero-padded rows per column beat, lane k skewed by k cycles.
// Optional macro ISB_STRIDE2_EN advances each window by two padded rows instead of one.
module input_skew_buffer #(
  parameter int DW  = 16,
  parameter int IMG = 7,
  parameter int PAD = 1,
  parameter int K   = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic [K-1:0]    out_valid,
  output logic [K*DW-1:0] out_data,
  output logic            busy,
  output logic            frame_done
);
  localparam int SIZE = IMG + 2*PAD;
`ifdef ISB_STRIDE2_EN
  localparam int STRIDE = 2;
`else
  localparam int STRIDE = 1;
`endif
  localparam int NWIN = (SIZE - K) / STRIDE + 1;
  localparam int NPIX = IMG * IMG;
  localparam int NST  = K * (K + 1) / 2;
  localparam int CW   = $clog2(SIZE + 1);
  localparam int RW   = $clog2(IMG + 1);
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int DCW  = $clog2(K + 2);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic [RW-1:0]  wr_col, rows_done;
  logic [CW-1:0]  rd_w, rd_c;
  logic [DCW-1:0] drain_cnt;
  logic [DW-1:0]  mem [NPIX];
  logic [DW-1:0]  rd_val [K];
  logic [DW-1:0]  st_dat [NST];
  logic [NST-1:0] st_vld;
  logic           wr_fire, rows_ok, issue, last_beat;
  logic [AW-1:0]  wr_addr;

  // rows_done is also the current write row, since it counts completed rows.
  assign wr_fire   = in_valid && in_ready && !load;
  assign wr_addr   = AW'(int'(rows_done) * IMG + int'(wr_col));
  assign issue     = (state == RUN) && rows_ok;
  assign last_beat = (rd_w == CW'(NWIN - 1)) && (rd_c == CW'(SIZE - 1));

  always_comb begin
    int need;
    need = int'(rd_w) * STRIDE + K - PAD;
    if (need > IMG) need = IMG;
    rows_ok = int'(rows_done) >= need;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      RUN:     if (issue && last_beat) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == DCW'(K)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (load) state_nxt = RUN;
  end

  always_comb begin
    in_ready   = (state == RUN) && (rows_done != RW'(IMG));
    busy       = (state != IDLE);
    frame_done = (state == DRAIN) && (drain_cnt == DCW'(K));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_col    <= '0;
      rows_done <= '0;
      rd_w      <= '0;
      rd_c      <= '0;
      drain_cnt <= '0;
    end else if (load) begin
      wr_col    <= '0;
      rows_done <= '0;
      rd_w      <= '0;
      rd_c      <= '0;
      drain_cnt <= '0;
    end else begin
      if (wr_fire) begin
        if (wr_col == RW'(IMG - 1)) begin
          wr_col    <= '0;
          rows_done <= rows_done + 1'b1;
        end else begin
          wr_col <= wr_col + 1'b1;
        end
      end
      if (issue) begin
        if (rd_c == CW'(SIZE - 1)) begin
          rd_c <= '0;
          rd_w <= rd_w + 1'b1;
        end else begin
          rd_c <= rd_c + 1'b1;
        end
      end
      drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_addr] <= in_data;
  end

  // Padding is synthesised here: coordinates outside the stored image read as zero.
  always_comb begin
    int r, c;
    r = 0;
    c = int'(rd_c) - PAD;
    for (int k = 0; k < K; k++) begin
      r = int'(rd_w) * STRIDE + k - PAD;
      rd_val[k] = '0;
      if (issue && r >= 0 && r < IMG && c >= 0 && c < IMG)
        rd_val[k] = mem[AW'(r * IMG + c)];
    end
  end

  // Triangular delay store: lane k owns entries k(k+1)/2 .. k(k+1)/2+k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NST; i++) st_dat[i] <= '0;
      st_vld <= '0;
    end else if (load) begin
      for (int i = 0; i < NST; i++) st_dat[i] <= '0;
      st_vld <= '0;
    end else begin
      for (int k = 0; k < K; k++) begin
        for (int j = 0; j <= k; j++) begin
          if (j == 0) begin
            st_dat[k*(k+1)/2] <= rd_val[k];
            st_vld[k*(k+1)/2] <= issue;
          end else begin
            st_dat[k*(k+1)/2 + j] <= st_dat[k*(k+1)/2 + j - 1];
            st_vld[k*(k+1)/2 + j] <= st_vld[k*(k+1)/2 + j - 1];
          end
        end
      end
    end
  end

  always_comb begin
    out_data  = '0;
    out_valid = '0;
    for (int k = 0; k < K; k++) begin
      out_data[k*DW +: DW] = st_dat[k*(k+1)/2 + k];
      out_valid[k]         = st_vld[k*(k+1)/2 + k];
    end
  end
endmodule

// File: tb/tb_input_skew_buffer.sv
// Randomised bench for input_skew_buffer with a frame-level reference model checked every cycle.
`timescale 1ns/1ps
module tb_input_skew_buffer;
  localparam int DW   = 16;
  localparam int IMG  = 7;
  localparam int PAD  = 1;
  localparam int K    = 3;
  localparam int SIZE = IMG + 2*PAD;
`ifdef ISB_STRIDE2_EN
  localparam int S = 2;
`else
  localparam int S = 1;
`endif
  localparam int NWIN  = (SIZE - K) / S + 1;
  localparam int NBEAT = NWIN * SIZE;
  localparam int NPIX  = IMG * IMG;

  logic clk = 1'b0;
  logic rst, load, in_valid, in_ready, busy, frame_done;
  logic [DW-1:0]   in_data;
  logic [K-1:0]    out_valid;
  logic [K*DW-1:0] out_data;

  input_skew_buffer #(.DW(DW), .IMG(IMG), .PAD(PAD), .K(K)) dut (
    .clk(clk), .rst(rst), .load(load), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
    .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the frame image, the padded-window rule and beat counters.
  logic [DW-1:0] img [NPIX];
  int m_phase = 0;   // 0 idle, 1 running, 2 draining
  int m_beats = 0;
  int m_pix   = 0;
  int m_dcnt  = 0;
  logic [K-1:0] m_hist = '0;
  logic m_issue;
  int lane_cnt [K];
  int first_t  [K];
  logic [DW-1:0] cap [K][2*SIZE];
  int fd_count = 0;
  int cyc = 0;

  function automatic logic [DW-1:0] pad_pix(input int r, input int c);
    if (r < PAD || r >= PAD + IMG || c < PAD || c >= PAD + IMG) return '0;
    return img[(r - PAD) * IMG + (c - PAD)];
  endfunction

  function automatic logic [DW-1:0] exp_beat(input int k, input int n);
    return pad_pix((n / SIZE) * S + k, n % SIZE);
  endfunction

  function automatic int need_rows(input int w);
    int n;
    n = w * S + K - PAD;
    return (n > IMG) ? IMG : n;
  endfunction

  task automatic model_clear(input int phase);
    m_phase = phase;
    m_beats = 0;
    m_pix   = 0;
    m_dcnt  = 0;
    m_hist  = '0;
    for (int k = 0; k < K; k++) begin
      lane_cnt[k] = 0;
      first_t[k]  = -1;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      model_clear(0);
      check("rst out_valid", out_valid, 0);
      check("rst busy", busy, 0);
    end else begin
      check("in_ready", in_ready, (m_phase == 1 && m_pix < NPIX));
      check("busy", busy, (m_phase != 0));
      check("frame_done", frame_done, (m_phase == 2 && m_dcnt == K));
      for (int k = 0; k < K; k++) begin
        check("lane valid", out_valid[k], m_hist[k]);
        if (out_valid[k]) begin
          check("lane data", out_data[k*DW +: DW], exp_beat(k, lane_cnt[k]));
          if (lane_cnt[k] < 2*SIZE) cap[k][lane_cnt[k]] = out_data[k*DW +: DW];
          if (first_t[k] < 0) first_t[k] = cyc;
          lane_cnt[k]++;
        end else begin
          check("lane idle zero", out_data[k*DW +: DW], 0);
        end
      end
      if (frame_done) fd_count++;
      m_issue = (m_phase == 1) && ((m_pix / IMG) >= need_rows(m_beats / SIZE));
      if (load) begin
        model_clear(1);
      end else begin
        m_hist = (m_hist << 1) | K'(m_issue);
        if (in_valid && m_phase == 1 && m_pix < NPIX) m_pix++;
        if (m_phase == 2) begin
          if (m_dcnt == K) m_phase = 0;
          else m_dcnt++;
        end
        if (m_issue) begin
          m_beats++;
          if (m_beats == NBEAT) begin
            m_phase = 2;
            m_dcnt  = 0;
          end
        end
      end
    end
  end

  task automatic start_frame();
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic feed(input int from, input int to, input int gap);
    int p;
    int t;
    logic hs;
    p = from;
    t = 0;
    while (p < to && t < 4000) begin
      in_valid = ($urandom_range(99) >= gap);
      in_data  = img[p];
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) p++;
      t++;
    end
    in_valid = 1'b0;
    check("feed complete", p, to);
  endtask

  task automatic wait_done(input int budget);
    int f0;
    int t;
    f0 = fd_count;
    t  = 0;
    while (fd_count == f0 && t < budget) begin
      @(posedge clk); #1;
      t++;
    end
    check("frame_done seen once", fd_count - f0, 1);
    check("idle after frame", busy, 0);
    for (int k = 0; k < K; k++) check("beats per lane", lane_cnt[k], NBEAT);
  endtask

  task automatic rand_img();
    for (int i = 0; i < NPIX; i++) img[i] = DW'($urandom);
  endtask

  int lit1 [SIZE] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
  int lit2 [SIZE] = '{0, 8, 9, 10, 11, 12, 13, 14, 0};

  initial begin
    int p;
    int fdb;
    logic hs;
    rst = 1'b1; load = 1'b0; in_valid = 1'b0; in_data = '0;
    for (int i = 0; i < NPIX; i++) img[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 0);
    check("reset out_data", out_data, 0);
    check("reset busy", busy, 0);
    check("reset frame_done", frame_done, 0);
    check("reset in_ready", in_ready, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Frame 1: ramp image, gapless.
    start_frame();
    for (int i = 0; i < NPIX; i++) img[i] = DW'(i + 1);
    feed(0, NPIX, 0);
    wait_done(1000);
    for (int i = 0; i < SIZE; i++) begin
      check("lane0 window0", cap[0][i], 0);
      check("lane1 window0", cap[1][i], lit1[i]);
      check("lane2 window0", cap[2][i], lit2[i]);
`ifdef ISB_STRIDE2_EN
      check("lane0 window1", cap[0][SIZE + i], lit2[i]);
`else
      check("lane0 window1", cap[0][SIZE + i], lit1[i]);
`endif
    end
    check("lane1 skew", first_t[1] - first_t[0], 1);
    check("lane2 skew", first_t[2] - first_t[0], 2);

    // Frame 2: three image rows, then a long hold; only windows fed by those rows stream.
    start_frame();
    rand_img();
    feed(0, 3*IMG, 0);
    repeat (60) @(posedge clk);
    #1;
`ifdef ISB_STRIDE2_EN
    check("stalled beats lane0", lane_cnt[0], SIZE);
`else
    check("stalled beats lane0", lane_cnt[0], 2*SIZE);
`endif
    check("stalled out_valid", out_valid, 0);
    check("stalled busy", busy, 1);
    feed(3*IMG, NPIX, 30);
    wait_done(1000);

    // Frame 3: random input gaps.
    start_frame();
    rand_img();
    feed(0, NPIX, 50);
    check("in_ready after full frame", in_ready, 0);
    wait_done(1000);

    // Frame 4: abort at lane0 beat 20, restart, complete.
    start_frame();
    rand_img();
    p = 0;
    for (int t = 0; t < 500 && lane_cnt[0] < 20; t++) begin
      in_valid = (p < NPIX);
      in_data  = img[p % NPIX];
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      if (hs) p++;
    end
    in_valid = 1'b0;
    check("reached beat 20", lane_cnt[0], 20);
    fdb = fd_count;
    start_frame();
    check("abort clears valid", out_valid, 0);
    check("abort clears data", out_data, 0);
    rand_img();
    feed(0, NPIX, 0);
    wait_done(1000);
    check("single frame_done across abort", fd_count - fdb, 1);

    // Frame 5: asynchronous reset mid-stream.
    start_frame();
    rand_img();
    feed(0, 30, 0);
    rst = 1'b1;
    #1;
    check("async rst out_valid", out_valid, 0);
    check("async rst out_data", out_data, 0);
    check("async rst busy", busy, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int t = 0; t < 30; t++) begin
      in_valid = ($urandom_range(1) == 1);
      in_data  = DW'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("no output after rst", lane_cnt[0], 0);

    // Frame 6: recovery after reset.
    start_frame();
    rand_img();
    feed(0, NPIX, 20);
    wait_done(1000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
